clip_controller: RTL and testbench

- Consumer end of the button/switch command word produced by the input synchronizer.
- Decodes the 5-bit registered command word {abort, record, play, clip_sel_wr, clip_sel_rd} and runs the two-clip audio record/playback sequencer.
- Paces samples with an internal sample-rate divider, drives the clip memory port, and tracks the recorded length of each clip.
- Playback streams only the samples actually recorded.

---
 rtl/clip_controller.sv | 177 +++++++++++++++++
 tb/tb_clip_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_controller.sv
// Two-clip audio record/playback sequencer driven by the registered command word.
// Paces samples with an internal divider and tracks the recorded length of each clip.
module clip_controller #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        cmd,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_valid,
  output logic              recording,
  output logic              playing,
  output logic              done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE, REC, PLAY, PLAY_WAIT} state_t;

  state_t            state;
  logic [1:0]        cmd_d;
  logic              clip;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len [2];
  logic [DIV_W-1:0]  div;
  logic              last_rd;
  logic              rd_pend;

  logic              rec_rise;
  logic              play_rise;
  logic              abort;
  logic              tick;
  logic [ADDR_W:0]   ptr_ext;
  logic [ADDR_W:0]   play_len;
  logic [ADDR_W:0]   last_idx;

  always_comb begin
    rec_rise  = cmd[3] & ~cmd_d[1];
    play_rise = cmd[2] & ~cmd_d[0];
    abort     = cmd[4];
    tick      = (div == DIV_W'(SAMPLE_DIV - 1));
    ptr_ext   = {1'b0, ptr};
    play_len  = len[cmd[0]];
    last_idx  = len[clip] - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cmd_d       <= '0;
      clip        <= 1'b0;
      ptr         <= '0;
      div         <= '0;
      len[0]      <= '0;
      len[1]      <= '0;
      last_rd     <= 1'b0;
      rd_pend     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_wdata   <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      recording   <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      cmd_d       <= cmd[3:2];
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      audio_valid <= 1'b0;
      done        <= 1'b0;
      rd_pend     <= 1'b0;

      // Read data arrives the cycle after mem_re; an abort discards it.
      if (rd_pend && !abort) begin
        audio_out   <= mem_rdata;
        audio_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rec_rise) begin
            state     <= REC;
            clip      <= cmd[1];
            ptr       <= '0;
            div       <= '0;
            recording <= 1'b1;
          end else if (play_rise && play_len != '0) begin
            state   <= PLAY;
            clip    <= cmd[0];
            ptr     <= '0;
            div     <= '0;
            last_rd <= 1'b0;
            playing <= 1'b1;
          end
        end

        REC: begin
          if (abort) begin
            len[clip] <= ptr_ext;
            state     <= IDLE;
            done      <= 1'b1;
            recording <= 1'b0;
          end else if (tick) begin
            mem_we    <= 1'b1;
            mem_addr  <= {clip, ptr};
            mem_wdata <= sample_in;
            ptr       <= ptr + ADDR_W'(1);
            div       <= '0;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
              len[clip] <= (ADDR_W + 1)'(DEPTH);
              state     <= IDLE;
              done      <= 1'b1;
              recording <= 1'b0;
            end else if (!cmd[3]) begin
              len[clip] <= ptr_ext + (ADDR_W + 1)'(1);
              state     <= IDLE;
              done      <= 1'b1;
              recording <= 1'b0;
            end
          end else if (!cmd[3]) begin
            len[clip] <= ptr_ext;
            state     <= IDLE;
            done      <= 1'b1;
            recording <= 1'b0;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        PLAY: begin
          if (abort) begin
            state   <= IDLE;
            done    <= 1'b1;
            playing <= 1'b0;
          end else begin
            if (tick) begin
              mem_re   <= 1'b1;
              mem_addr <= {clip, ptr};
              ptr      <= ptr + ADDR_W'(1);
              last_rd  <= (ptr_ext == last_idx);
              div      <= '0;
            end else begin
              div <= div + DIV_W'(1);
            end
            if (mem_re) begin
              rd_pend <= 1'b1;
            end
            // PLAY_WAIT is the cycle in which the last read's data is on mem_rdata.
            if (mem_re && last_rd) begin
              state <= PLAY_WAIT;
            end
          end
        end

        PLAY_WAIT: begin
          state   <= IDLE;
          done    <= 1'b1;
          playing <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clip_controller.sv
// Scoreboard bench for clip_controller: expected writes/audio are queued as stimulus is
// driven and popped as the DUT strobes mem_we/audio_valid.
module tb_clip_controller;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int DEP = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    cmd;
  logic [DW-1:0] sample_in;
  logic [DW-1:0] mem_rdata;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] audio_out;
  logic          audio_valid;
  logic          recording;
  logic          playing;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  logic [AW+DW:0] wr_q[$];
  logic [DW-1:0]  rd_q[$];
  logic [DW-1:0]  mem [2*DEP];

  clip_controller #(.ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .cmd(cmd), .sample_in(sample_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .audio_out(audio_out), .audio_valid(audio_valid), .recording(recording),
    .playing(playing), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous clip memory: read data valid the cycle after mem_re.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (!reset) begin
      compared++;
      if ((mem_we && mem_re) || (recording && playing)) begin
        mismatched++;
        $display("FAIL exclusion: we=%0b re=%0b rec=%0b play=%0b, required no overlap",
                 mem_we, mem_re, recording, playing);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [31:0] outs;
    @(negedge clock);
    reset = 1'b1; cmd = '0; sample_in = '0;
    repeat (3) @(negedge clock);
    outs = 32'({mem_addr, mem_we, mem_re, mem_wdata, audio_out, audio_valid, recording, playing, done});
    compared++;
    if (outs !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    reset = 1'b0;
    idle_cycles(2);
  endtask

  // n_rel = writes before releasing record; 0 holds record until the clip fills.
  task automatic test_record(input bit clp, input int n_rel, input int base);
    int exp_n, writes, dones, cyc, done_cyc, rel_cyc, last_wr_cyc;
    logic [AW+DW:0] exp_wr;
    exp_n = (n_rel == 0) ? DEP : n_rel;
    writes = 0; dones = 0; cyc = 0; done_cyc = -1; rel_cyc = -1; last_wr_cyc = -1;
    cmd = {1'b0, 1'b1, 1'b0, clp, 1'b0};
    sample_in = DW'(base);
    wr_q.push_back({clp, AW'(0), DW'(base)});
    repeat (4 * DEP + 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        compared++;
        if (recording !== 1'b1) begin
          mismatched++;
          $display("FAIL rec_flag: recording=%0b, required 1", recording);
        end
      end
      if (mem_we) begin
        compared++;
        if (wr_q.size() == 0) begin
          mismatched++;
          $display("FAIL rec_extra_write: addr=%0d data=%0d, required no write", mem_addr, mem_wdata);
        end else begin
          exp_wr = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_wr) begin
            mismatched++;
            $display("FAIL rec_write: addr/data=%0d/%0d, required %0d/%0d",
                     mem_addr, mem_wdata, exp_wr[AW+DW:DW], exp_wr[DW-1:0]);
          end
        end
        compared++;
        if (cyc != 5 + DIV * writes) begin
          mismatched++;
          $display("FAIL rec_write_time: write %0d at cycle %0d, required %0d", writes, cyc, 5 + DIV * writes);
        end
        writes++;
        last_wr_cyc = cyc;
        if (writes < exp_n) begin
          sample_in = DW'(base + writes);
          wr_q.push_back({clp, AW'(writes), DW'(base + writes)});
        end
        if (n_rel != 0 && writes == n_rel) begin
          cmd[3] = 1'b0;
          rel_cyc = cyc;
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    compared++;
    if (writes != exp_n) begin
      mismatched++;
      $display("FAIL rec_write_count: got %0d, required %0d", writes, exp_n);
    end
    compared++;
    if (dones != 1) begin
      mismatched++;
      $display("FAIL rec_done_count: got %0d, required 1", dones);
    end
    compared++;
    if (done_cyc != ((n_rel == 0) ? last_wr_cyc : rel_cyc + 1)) begin
      mismatched++;
      $display("FAIL rec_done_time: got %0d, required %0d", done_cyc,
               (n_rel == 0) ? last_wr_cyc : rel_cyc + 1);
    end
    compared++;
    if (recording !== 1'b0 || wr_q.size() != 0) begin
      mismatched++;
      $display("FAIL rec_end: recording=%0b pending=%0d, required 0/0", recording, wr_q.size());
    end
    cmd = '0;
    idle_cycles(2);
  endtask

  // abort_after = reads before asserting abort; 0 plays to the end.
  task automatic test_play(input bit clp, input int n, input int base, input int abort_after);
    int exp_reads, exp_valid, reads, valids, dones, cyc, done_cyc, ab_cyc, last_v_cyc;
    logic [DW-1:0] exp_a;
    exp_reads = (abort_after != 0) ? abort_after : n;
    exp_valid = (abort_after != 0) ? abort_after - 1 : n;
    reads = 0; valids = 0; dones = 0; cyc = 0; done_cyc = -1; ab_cyc = -1; last_v_cyc = -1;
    cmd = {1'b0, 1'b0, 1'b1, 1'b0, clp};
    for (int i = 0; i < exp_valid; i++) rd_q.push_back(DW'(base + i));
    repeat (DIV * n + 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        compared++;
        if (playing !== 1'b1) begin
          mismatched++;
          $display("FAIL play_flag: playing=%0b, required 1", playing);
        end
      end
      if (mem_re) begin
        compared++;
        if (mem_addr !== {clp, AW'(reads)}) begin
          mismatched++;
          $display("FAIL play_addr: got %0d, required %0d", mem_addr, {clp, AW'(reads)});
        end
        reads++;
        cmd[2] = 1'b0;
        if (abort_after != 0 && reads == abort_after) begin
          cmd[4] = 1'b1;
          ab_cyc = cyc;
        end
      end
      if (audio_valid) begin
        compared++;
        if (rd_q.size() == 0) begin
          mismatched++;
          $display("FAIL play_extra_valid: audio=%0d, required no strobe", audio_out);
        end else begin
          exp_a = rd_q.pop_front();
          if (audio_out !== exp_a) begin
            mismatched++;
            $display("FAIL play_audio: got %0d, required %0d", audio_out, exp_a);
          end
        end
        valids++;
        last_v_cyc = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    compared++;
    if (reads != exp_reads || valids != exp_valid) begin
      mismatched++;
      $display("FAIL play_counts: reads/valids=%0d/%0d, required %0d/%0d", reads, valids, exp_reads, exp_valid);
    end
    compared++;
    if (dones != 1) begin
      mismatched++;
      $display("FAIL play_done_count: got %0d, required 1", dones);
    end
    compared++;
    if (abort_after != 0 ? (done_cyc != ab_cyc + 1)
                         : (done_cyc != last_v_cyc || last_v_cyc != 7 + DIV * (n - 1))) begin
      mismatched++;
      $display("FAIL play_done_time: done at %0d last valid %0d, required %0d", done_cyc, last_v_cyc,
               (abort_after != 0) ? ab_cyc + 1 : 7 + DIV * (n - 1));
    end
    compared++;
    if (playing !== 1'b0 || rd_q.size() != 0) begin
      mismatched++;
      $display("FAIL play_end: playing=%0b pending=%0d, required 0/0", playing, rd_q.size());
    end
    rd_q.delete();
    cmd = '0;
    idle_cycles(2);
  endtask

  task automatic test_empty_clip(input bit clp);
    int reads, plays, dones;
    reads = 0; plays = 0; dones = 0;
    cmd = {1'b0, 1'b0, 1'b1, 1'b0, clp};
    repeat (3 * DIV + 4) begin
      @(negedge clock);
      if (mem_re) reads++;
      if (playing) plays++;
      if (done) dones++;
    end
    compared++;
    if (reads != 0 || plays != 0 || dones != 0) begin
      mismatched++;
      $display("FAIL empty_clip: reads/playing/done=%0d/%0d/%0d, required 0/0/0", reads, plays, dones);
    end
    cmd = '0;
    idle_cycles(2);
  endtask

  task automatic test_simultaneous;
    cmd = 5'b01110;
    @(negedge clock);
    compared++;
    if ({recording, playing} !== 2'b10) begin
      mismatched++;
      $display("FAIL simultaneous: rec/play=%0b%0b, required 10", recording, playing);
    end
    cmd = '0;
    @(negedge clock);
    compared++;
    if (done !== 1'b1 || recording !== 1'b0) begin
      mismatched++;
      $display("FAIL simul_release: done=%0b rec=%0b, required 1/0", done, recording);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid;
    int writes, budget;
    logic [31:0] outs;
    writes = 0; budget = 0;
    cmd = 5'b01000;
    sample_in = 8'd99;
    while (writes < 3 && budget < 40) begin
      @(negedge clock);
      budget++;
      if (mem_we) writes++;
    end
    compared++;
    if (writes != 3) begin
      mismatched++;
      $display("FAIL reset_mid_writes: got %0d, required 3", writes);
    end
    reset = 1'b1;
    cmd = '0;
    @(negedge clock);
    outs = 32'({mem_addr, mem_we, mem_re, mem_wdata, audio_out, audio_valid, recording, playing, done});
    compared++;
    if (outs !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    reset = 1'b0;
    idle_cycles(2);
    test_empty_clip(1'b0);
    test_empty_clip(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2 * DEP; i++) mem[i] = '0;
    mem_rdata = '0;
    test_reset();
    test_record(1'b0, 5, 10);
    test_play(1'b0, 5, 10, 0);
    test_empty_clip(1'b1);
    test_record(1'b1, 0, 20);
    test_play(1'b1, DEP, 20, 0);
    test_play(1'b0, 5, 10, 2);
    test_play(1'b0, 5, 10, 0);
    test_simultaneous();
    test_empty_clip(1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
